// File: rtl/v810_regfile_mp.sv
// Multi-port V810 register file: NRD combinational read ports, two write ports,
// a per-register pending-load scoreboard, and a clear engine that zeroes the array after reset.
module v810_regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] RD,
    output logic [NRD-1:0]    SB_BUSY,
    input  logic [AW-1:0]     WA0,
    input  logic [DW-1:0]     WD0,
    input  logic              WE0,
    input  logic [AW-1:0]     WA1,
    input  logic [DW-1:0]     WD1,
    input  logic              WE1,
    input  logic              SB_SET,
    input  logic [AW-1:0]     SB_SA,
    output logic              SB_ANY,
    output logic              INIT_BUSY
);

    // state   | meaning
    // S_CLEAR | clear engine zeroing entry r_cnt on each CE cycle; array not valid
    // S_READY | normal operation: reads, writes, scoreboard updates
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_R0 != 0);

    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_ready;
    logic w_commit;
    logic w_we0;
    logic w_we1;
    logic w_sb_set;
    logic w_sb_clr;
    logic w_clear_wr;

    assign w_ready    = (r_state == S_READY) && !RESET;
    assign w_commit   = w_ready && CE;
    assign w_we0      = w_commit && WE0 && !(ZR && (WA0 == '0));
    assign w_we1      = w_commit && WE1 && !(ZR && (WA1 == '0));
    assign w_sb_set   = w_commit && SB_SET && !(ZR && (SB_SA == '0));
    assign w_sb_clr   = w_commit && WE1;
    assign w_clear_wr = !RESET && CE && (r_state == S_CLEAR);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= '0;
        end else if (CE) begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    // Set is applied after clear so a new load supersedes a same-cycle return.
                    if (w_sb_clr) begin
                        r_busy[WA1] <= 1'b0;
                    end
                    if (w_sb_set) begin
                        r_busy[SB_SA] <= 1'b1;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_clear_wr) begin
            r_mem[r_cnt] <= '0;
        end else begin
            // Port 1 is written last so it wins a same-address collision.
            if (w_we0) begin
                r_mem[WA0] <= WD0;
            end
            if (w_we1) begin
                r_mem[WA1] <= WD1;
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_r0;
        logic          w_hit0;
        logic          w_hit1;

        assign w_ra   = RA[gi*AW +: AW];
        assign w_r0   = ZR && (w_ra == '0);
        assign w_hit1 = CE && WE1 && (WA1 == w_ra);
        assign w_hit0 = CE && WE0 && (WA0 == w_ra);

        assign RD[gi*DW +: DW] = (!w_ready || w_r0) ? '0  :
                                 w_hit1             ? WD1 :
                                 w_hit0             ? WD0 :
                                                      r_mem[w_ra];

        assign SB_BUSY[gi] = w_ready && !w_r0 && r_busy[w_ra] && !w_hit1;
    end

    assign SB_ANY    = |r_busy;
    assign INIT_BUSY = !w_ready;

endmodule

// File: doc/v810_regfile_mp.md
Name: v810_regfile_mp

Overview:
Parametrised multi-port successor to the V810 register file. It provides NRD combinational read ports and two write ports: port 0 for pipeline writeback and port 1 for load/bus returns. It adds per-register pending-load scoreboard bits, and a sequential clear engine that zeroes the array after reset. It sits between decode/execute (reads, scoreboard queries) and writeback/bus unit (writes).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW entries
NRD, 3, number of read ports
ZERO_R0, 1, 1 = entry 0 reads as zero, ignores writes and ignores scoreboard sets

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset; sampled on CLK posedge, ignores CE
CE  in  1  global clock enable; all state changes except RESET are gated by CE
RA  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
RD  out  NRD*DW  read data; port i uses bits [i*DW +: DW]
SB_BUSY  out  NRD  bit i = register RA[i] has a load pending
WA0  in  AW  write port 0 address
WD0  in  DW  write port 0 data
WE0  in  1  write port 0 enable
WA1  in  AW  write port 1 (load return) address
WD1  in  DW  write port 1 data
WE1  in  1  write port 1 enable; also clears the scoreboard bit for WA1
SB_SET  in  1  mark register SB_SA as load-pending
SB_SA  in  AW  scoreboard set address
SB_ANY  out  1  OR of all scoreboard bits
INIT_BUSY  out  1  clear engine active; array not valid

Behaviour:
- States: CLEAR, READY. RESET=1 at posedge -> CLEAR, clear counter cnt=0, all scoreboard bits=0. This happens from any state, including mid-clear.
- CLEAR: on each CE cycle, write 0 to entry cnt and increment cnt. When cnt = 2**AW-1 is written -> READY. Duration is 2**AW CE cycles after RESET deasserts.
- INIT_BUSY=1 while RESET is high or state=CLEAR. INIT_BUSY=0 in READY.
- During CLEAR: WE0/WE1/SB_SET ignored; RD all zero; SB_BUSY=0; SB_ANY=0.
- Outputs after reset (before first CE): RD=0, SB_BUSY=0, SB_ANY=0, INIT_BUSY=1.
- Writes (READY, CE=1): WE0 writes WD0 to WA0, WE1 writes WD1 to WA1. If both target the same address, port 1 wins. With ZERO_R0=1, writes to address 0 are dropped.
- Read (combinational, zero latency), per port i, first match wins:
  1. ZERO_R0 and RA[i]=0 -> 0.
  2. CE & WE1 & WA1=RA[i] -> WD1.
  3. CE & WE0 & WA0=RA[i] -> WD0.
  4. Otherwise -> stored entry.
  Forwarding requires CE=1, so RD never shows a value that will not be committed.
- Scoreboard (READY, CE=1):
  - SB_SET sets busy[SB_SA].
  - WE1 clears busy[WA1].
  - Same address set and clear in one cycle -> bit ends set (new load supersedes).
  - ZERO_R0 and SB_SA=0 -> ignored.
  - Write port 0 does not affect the scoreboard.
- SB_BUSY[i] = busy[RA[i]] & ~(CE & WE1 & WA1=RA[i]). A returning load un-busies the register in the same cycle; the new set is not visible until the next cycle. SB_BUSY=0 for address 0 when ZERO_R0=1.
- SB_ANY is registered-state-based: the OR of busy[] with no bypass.
- CE=0: no state change, no forwarding; RD shows stored contents.
- Each read port is independent; any ports may share one address.

Test Plan:
- Reset with AW=5: RESET 1 cycle, then 32 CE cycles -> INIT_BUSY drops exactly after the 32nd. Every RA reads 0. A WE0 issued during CLEAR is not written (later read = 0).
- Forwarding and priority: WE0 WA0=3 WD0=0x1111, WE1 WA1=3 WD1=0x2222, RA[0]=3 in same cycle -> RD0=0x2222. Next cycle RD0=0x2222.
- r0 with ZERO_R0=1: WE0 WA0=0 WD0=0xFFFFFFFF, SB_SET SB_SA=0 -> RD for RA=0 stays 0, SB_BUSY=0, SB_ANY=0.
- Scoreboard:
  - SB_SET SB_SA=7 -> next cycle SB_BUSY=1 on ports reading 7, SB_ANY=1.
  - Later WE1 WA1=7 WD1=0xABCD -> same cycle SB_BUSY=0, RD=0xABCD. Next cycle SB_ANY=0.
  - SB_SET and WE1 both on address 9 -> bit remains set.
- CE gating: CE=0 with WE0 WA0=5 WD0=0x55 -> RD for 5 unchanged this cycle and after. With CE=1, the same write commits.
- Reset mid-clear and mid-operation: RESET at cnt=10 -> cnt restarts at 0, a full 32 cycles elapse again. RESET with busy[4]=1 -> busy cleared, entry 4 reads 0 after CLEAR.
